// File: rtl/thread_pc_unit_pkg.sv
// Shared types and constants for the thread PC unit and its neighbours.
package common;
  localparam int n_threads = 4;

  typedef logic [1:0]  threadid_t;
  typedef logic [31:0] vptr_t;

  typedef enum logic [1:0] {
    RUN,
    WAIT,
    HALT
  } thread_state_t;

  localparam vptr_t BOOT_PC    = 32'h0000_1000;
  localparam vptr_t EXC_VECTOR = 32'h0000_2000;
endpackage

// File: rtl/thread_pc_unit_pc_slot.sv
// One hardware thread's PC register and RUN/WAIT/HALT state machine.
module pc_slot
  import common::*;
#(
  parameter vptr_t RESET_PC  = 32'h0000_1000,
  parameter vptr_t TRAP_PC   = 32'h0000_2000,
  parameter bit    RESET_RUN = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt,
  input  logic          start,
  input  vptr_t         start_pc,
  input  logic          redirect,
  input  vptr_t         redirect_pc,
  input  logic          fb_hit,
  input  vptr_t         fb_pc,
  input  logic          fb_itlb_miss,
  input  logic          fb_icache_miss,
  input  logic          fill_pending,
  output vptr_t         pc,
  output thread_state_t state,
  output logic          exc_req
);

  // A fetch result only counts if it is for the PC we currently hold;
  // anything else is a squashed wrong-path fetch.
  logic fb_accept;
  assign fb_accept = fb_hit && (state == RUN) && (fb_pc == pc);
  assign exc_req   = fb_accept && fb_itlb_miss && !halt && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= RESET_RUN ? RUN : HALT;
    end else if (halt) begin
      state <= HALT;
    end else if (start && (state == HALT)) begin
      pc    <= start_pc;
      state <= RUN;
    end else if (redirect && (state != HALT)) begin
      pc    <= redirect_pc;
      state <= RUN;
    end else if (fb_accept) begin
      // The I-TLB miss wins over an I-cache miss on the same fetch.
      if (fb_itlb_miss) begin
        pc <= TRAP_PC;
      end else if (fb_icache_miss) begin
        state <= WAIT;
      end else begin
        pc <= fb_pc + 32'd4;
      end
    end else if ((state == WAIT) && !fill_pending) begin
      state <= RUN;
    end
  end

endmodule

// File: rtl/thread_pc_unit.sv
// Per-thread PC keeper upstream of fetch: decodes events per thread and
// registers the I-TLB-miss exception report.
module thread_pc_unit
  import common::*;
#(
  parameter int    N_THREADS  = n_threads,
  parameter vptr_t BOOT_PC    = 32'h0000_1000,
  parameter vptr_t EXC_VECTOR = 32'h0000_2000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fb_valid,
  input  threadid_t            fb_thread,
  input  vptr_t                fb_pc,
  input  logic                 fb_itlb_miss,
  input  logic                 fb_icache_miss,
  input  logic [N_THREADS-1:0] icache_stalled,
  input  logic                 redirect_en,
  input  threadid_t            redirect_thread,
  input  vptr_t                redirect_pc,
  input  logic                 halt_en,
  input  threadid_t            halt_thread,
  input  logic                 start_en,
  input  threadid_t            start_thread,
  input  vptr_t                start_pc,
  output vptr_t                pc [N_THREADS],
  output logic [N_THREADS-1:0] thread_active,
  output logic                 exc_valid,
  output threadid_t            exc_thread,
  output vptr_t                exc_epc
);

  logic [N_THREADS-1:0] exc_req;
  thread_state_t        slot_state [N_THREADS];

  for (genvar t = 0; t < N_THREADS; t++) begin : g_slot
    pc_slot #(
      .RESET_PC (BOOT_PC),
      .TRAP_PC  (EXC_VECTOR),
      .RESET_RUN(t == 0)
    ) u_slot (
      .clk           (clk),
      .rst           (rst),
      .halt          (halt_en && (halt_thread == threadid_t'(t))),
      .start         (start_en && (start_thread == threadid_t'(t))),
      .start_pc      (start_pc),
      .redirect      (redirect_en && (redirect_thread == threadid_t'(t))),
      .redirect_pc   (redirect_pc),
      .fb_hit        (fb_valid && (fb_thread == threadid_t'(t))),
      .fb_pc         (fb_pc),
      .fb_itlb_miss  (fb_itlb_miss),
      .fb_icache_miss(fb_icache_miss),
      .fill_pending  (icache_stalled[t]),
      .pc            (pc[t]),
      .state         (slot_state[t]),
      .exc_req       (exc_req[t])
    );

    assign thread_active[t] = (slot_state[t] == RUN);
  end

  // Only one fetch result arrives per cycle, so at most one slot raises a
  // request and the fetch-bus fields identify it directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_valid  <= 1'b0;
      exc_thread <= '0;
      exc_epc    <= '0;
    end else begin
      exc_valid <= |exc_req;
      if (|exc_req) begin
        exc_thread <= fb_thread;
        exc_epc    <= fb_pc;
      end
    end
  end

endmodule

// File: tb/tb_thread_pc_unit.sv
// Randomized scoreboard bench for thread_pc_unit against a rule-level model.
module tb_thread_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fb_valid;
  logic [1:0]  fb_thread;
  logic [31:0] fb_pc;
  logic        fb_itlb_miss;
  logic        fb_icache_miss;
  logic [3:0]  icache_stalled;
  logic        redirect_en;
  logic [1:0]  redirect_thread;
  logic [31:0] redirect_pc;
  logic        halt_en;
  logic [1:0]  halt_thread;
  logic        start_en;
  logic [1:0]  start_thread;
  logic [31:0] start_pc;
  logic [31:0] dut_pc [4];
  logic [3:0]  thread_active;
  logic        exc_valid;
  logic [1:0]  exc_thread;
  logic [31:0] exc_epc;

  always #5 clk = ~clk;

  thread_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .fb_valid       (fb_valid),
    .fb_thread      (fb_thread),
    .fb_pc          (fb_pc),
    .fb_itlb_miss   (fb_itlb_miss),
    .fb_icache_miss (fb_icache_miss),
    .icache_stalled (icache_stalled),
    .redirect_en    (redirect_en),
    .redirect_thread(redirect_thread),
    .redirect_pc    (redirect_pc),
    .halt_en        (halt_en),
    .halt_thread    (halt_thread),
    .start_en       (start_en),
    .start_thread   (start_thread),
    .start_pc       (start_pc),
    .pc             (dut_pc),
    .thread_active  (thread_active),
    .exc_valid      (exc_valid),
    .exc_thread     (exc_thread),
    .exc_epc        (exc_epc)
  );

  typedef struct {
    bit        rst;
    bit        fb_valid;
    bit [1:0]  fb_thread;
    bit [31:0] fb_pc;
    bit        itlb;
    bit        icm;
    bit [3:0]  stalled;
    bit        redir_en;
    bit [1:0]  redir_t;
    bit [31:0] redir_pc;
    bit        halt_en;
    bit [1:0]  halt_t;
    bit        start_en;
    bit [1:0]  start_t;
    bit [31:0] start_pc;
  } stim_t;

  typedef struct packed {
    logic [3:0][31:0] pc;
    logic [3:0]       active;
    logic             exc_v;
    logic [1:0]       exc_t;
    logic [31:0]      exc_epc;
  } expect_t;

  localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2;

  // Reference model: thread status as plain integers, PCs as words.
  bit [31:0] m_pc [4];
  int        m_st [4];
  bit        m_ev;
  bit [1:0]  m_et;
  bit [31:0] m_epc;

  expect_t   sb_q [$];
  int        checkCount = 0;
  int        passCount  = 0;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic checkOutput(input expect_t e);
    for (int i = 0; i < 4; i++) checkValue($sformatf("pc[%0d]", i), dut_pc[i], e.pc[i]);
    checkValue("thread_active", {28'd0, thread_active}, {28'd0, e.active});
    checkValue("exc_valid", {31'd0, exc_valid}, {31'd0, e.exc_v});
    checkValue("exc_thread", {30'd0, exc_thread}, {30'd0, e.exc_t});
    checkValue("exc_epc", exc_epc, e.exc_epc);
  endtask

  // Apply one cycle's worth of events to the model, following the rules:
  // halt beats everything, start only wakes a halted thread, redirect beats
  // feedback, and feedback only counts when it matches the held PC.
  task automatic modelStep(input stim_t s);
    if (s.rst) begin
      for (int t = 0; t < 4; t++) begin
        m_pc[t] = 32'h0000_1000;
        m_st[t] = (t == 0) ? M_RUN : M_HALT;
      end
      m_ev = 0; m_et = 0; m_epc = 0;
      return;
    end
    m_ev = 0;
    for (int t = 0; t < 4; t++) begin
      bit hit_halt, hit_start, hit_redir, hit_fb;
      hit_halt  = s.halt_en && s.halt_t == t;
      hit_start = s.start_en && s.start_t == t && m_st[t] == M_HALT;
      hit_redir = s.redir_en && s.redir_t == t && m_st[t] != M_HALT;
      hit_fb    = s.fb_valid && s.fb_thread == t && m_st[t] == M_RUN && s.fb_pc == m_pc[t];
      if (hit_halt) m_st[t] = M_HALT;
      else if (hit_start) begin m_pc[t] = s.start_pc; m_st[t] = M_RUN; end
      else if (hit_redir) begin m_pc[t] = s.redir_pc; m_st[t] = M_RUN; end
      else if (hit_fb) begin
        if (s.itlb) begin
          m_pc[t] = 32'h0000_2000;
          m_ev = 1; m_et = 2'(t); m_epc = s.fb_pc;
        end else if (s.icm) m_st[t] = M_WAIT;
        else m_pc[t] = m_pc[t] + 32'd4;
      end else if (m_st[t] == M_WAIT && !s.stalled[t]) m_st[t] = M_RUN;
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    expect_t e;
    rst             = s.rst;
    fb_valid        = s.fb_valid;
    fb_thread       = s.fb_thread;
    fb_pc           = s.fb_pc;
    fb_itlb_miss    = s.itlb;
    fb_icache_miss  = s.icm;
    icache_stalled  = s.stalled;
    redirect_en     = s.redir_en;
    redirect_thread = s.redir_t;
    redirect_pc     = s.redir_pc;
    halt_en         = s.halt_en;
    halt_thread     = s.halt_t;
    start_en        = s.start_en;
    start_thread    = s.start_t;
    start_pc        = s.start_pc;
    modelStep(s);
    for (int t = 0; t < 4; t++) begin
      e.pc[t]     = m_pc[t];
      e.active[t] = (m_st[t] == M_RUN);
    end
    e.exc_v   = m_ev;
    e.exc_t   = m_et;
    e.exc_epc = m_epc;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic stim_t idle(input bit [3:0] stalled);
    stim_t s;
    s = '{default: 0};
    s.stalled = stalled;
    return s;
  endfunction

  // Monitor: every cycle the DUT presents a full new state just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) checkOutput(sb_q.pop_front());
    end
  end

  initial begin
    stim_t s;
    s = idle(4'h0);
    s.rst = 1;
    applyStimulus(s);
    applyStimulus(s);
    checkValue("reset active", {28'd0, thread_active}, 32'h1);

    s = idle(4'h0); s.fb_valid = 1; s.fb_thread = 0; s.fb_pc = 32'h1000;
    applyStimulus(s);
    checkValue("advance pc0", dut_pc[0], 32'h1004);

    s = idle(4'h4); s.start_en = 1; s.start_t = 2; s.start_pc = 32'h4000;
    applyStimulus(s);
    s = idle(4'h4); s.fb_valid = 1; s.fb_thread = 2; s.fb_pc = 32'h4000; s.icm = 1;
    applyStimulus(s);
    checkValue("wait holds pc2", dut_pc[2], 32'h4000);
    checkValue("wait inactive", {31'd0, thread_active[2]}, 32'h0);
    applyStimulus(idle(4'h4));
    checkValue("still waiting", {31'd0, thread_active[2]}, 32'h0);
    applyStimulus(idle(4'h0));
    checkValue("fill done", {31'd0, thread_active[2]}, 32'h1);

    s = idle(4'h0); s.start_en = 1; s.start_t = 1; s.start_pc = 32'h5000;
    applyStimulus(s);
    s = idle(4'h0); s.fb_valid = 1; s.fb_thread = 1; s.fb_pc = 32'h5000; s.itlb = 1; s.icm = 1;
    applyStimulus(s);
    checkValue("itlb vector", dut_pc[1], 32'h2000);
    checkValue("itlb exc_valid", {31'd0, exc_valid}, 32'h1);
    checkValue("itlb exc_epc", exc_epc, 32'h5000);
    applyStimulus(idle(4'h0));
    checkValue("exc pulse ends", {31'd0, exc_valid}, 32'h0);

    s = idle(4'h0); s.redir_en = 1; s.redir_t = 0; s.redir_pc = 32'h8000;
    s.fb_valid = 1; s.fb_thread = 0; s.fb_pc = 32'h1004;
    applyStimulus(s);
    s = idle(4'h0); s.fb_valid = 1; s.fb_thread = 0; s.fb_pc = 32'h1008;
    applyStimulus(s);
    checkValue("stale fb dropped", dut_pc[0], 32'h8000);

    s = idle(4'h0); s.halt_en = 1; s.halt_t = 3; s.start_en = 1; s.start_t = 3; s.start_pc = 32'h7000;
    applyStimulus(s);
    checkValue("halt beats start", {31'd0, thread_active[3]}, 32'h0);
    s = idle(4'h0); s.redir_en = 1; s.redir_t = 0; s.redir_pc = 32'hFFFF_FFFC;
    applyStimulus(s);
    s = idle(4'h0); s.fb_valid = 1; s.fb_thread = 0; s.fb_pc = 32'hFFFF_FFFC;
    applyStimulus(s);
    checkValue("pc wrap", dut_pc[0], 32'h0);

    s = idle(4'h4); s.fb_valid = 1; s.fb_thread = 2; s.fb_pc = 32'h4000; s.icm = 1;
    applyStimulus(s);
    s = idle(4'h4); s.rst = 1; s.fb_valid = 1; s.fb_thread = 1; s.fb_pc = 32'h2000; s.itlb = 1;
    applyStimulus(s);
    checkValue("rst pc2", dut_pc[2], 32'h1000);
    checkValue("rst active", {28'd0, thread_active}, 32'h1);
    checkValue("rst exc_valid", {31'd0, exc_valid}, 32'h0);

    for (int n = 0; n < 600; n++) begin
      s = idle(4'h0);
      s.rst       = ($urandom_range(0, 199) == 0);
      s.fb_valid  = ($urandom_range(0, 3) != 0);
      s.fb_thread = 2'($urandom_range(0, 3));
      s.fb_pc     = ($urandom_range(0, 3) != 0) ? m_pc[s.fb_thread] : ($urandom() & 32'hFFFF_FFFC);
      s.itlb      = ($urandom_range(0, 15) == 0);
      s.icm       = ($urandom_range(0, 5) == 0);
      for (int t = 0; t < 4; t++) s.stalled[t] = ($urandom_range(0, 2) != 0);
      s.redir_en  = ($urandom_range(0, 9) == 0);
      s.redir_t   = 2'($urandom_range(0, 3));
      s.redir_pc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      s.halt_en   = ($urandom_range(0, 39) == 0);
      s.halt_t    = 2'($urandom_range(0, 3));
      s.start_en  = ($urandom_range(0, 5) == 0);
      s.start_t   = 2'($urandom_range(0, 3));
      s.start_pc  = $urandom() & 32'hFFFF_FFFC;
      applyStimulus(s);
    end

    applyStimulus(idle(4'h0));
    repeat (2) @(posedge clk);
    #2;
    checkValue("scoreboard drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/thread_pc_unit.md
# thread_pc_unit

Per-thread program-counter and thread-state keeper that sits directly upstream of the fetch stage. Holds one PC and one run state per hardware thread and presents all PCs to fetch. Consumes the fetch-stage output (IF/ID register contents) to advance PCs by one word, replay on I-cache miss, and vector to the exception handler on I-TLB miss. Applies redirects from execute and thread start/halt commands.

## Interface
Parameters:
- N_THREADS, 4, hardware thread count (equals `common::n_threads`)
- BOOT_PC, 32'h0000_1000, reset PC of every thread
- EXC_VECTOR, 32'h0000_2000, I-TLB-miss handler entry

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fb_valid  in  1  fetch result present in IF/ID this cycle
- fb_thread  in  threadid_t  thread of fetch result
- fb_pc  in  vptr_t  PC that was fetched
- fb_itlb_miss  in  1  fetch missed I-TLB
- fb_icache_miss  in  1  fetch missed I-cache
- icache_stalled  in  N_THREADS  per-thread I-cache fill pending
- redirect_en / redirect_thread / redirect_pc  in  1 / threadid_t / vptr_t  branch, jump or iret target from execute
- halt_en / halt_thread  in  1 / threadid_t  park a thread
- start_en / start_thread / start_pc  in  1 / threadid_t / vptr_t  launch a halted thread
- pc  out  vptr_t[N_THREADS]  current PC per thread, to fetch
- thread_active  out  N_THREADS  thread may be scheduled (state RUN)
- exc_valid  out  1  I-TLB-miss exception pulse
- exc_thread  out  threadid_t  faulting thread
- exc_epc  out  vptr_t  faulting PC

## Operation
- Per-thread state: RUN, WAIT (I-cache fill outstanding), HALT.
- Reset: pc[t]=BOOT_PC for all t. state[0]=RUN, others HALT. exc_valid=0, exc_thread=0, exc_epc=0.
- Per-thread priority, highest first: halt, start, redirect, feedback.
- halt for t: state HALT, pc held. Any other event for t in that cycle is ignored.
- start for t: only if state HALT. Sets pc=start_pc and state RUN. Ignored otherwise.
- redirect for t: pc=redirect_pc. If state is WAIT, go RUN. Ignored in HALT. Same-cycle feedback for t is discarded.
- Feedback for t=fb_thread is accepted only if fb_valid, state RUN and fb_pc==pc[t]. A mismatch means a squashed wrong-path fetch; drop it silently.
- Accepted feedback with itlb_miss: pc=EXC_VECTOR, exc pulse carries t and fb_pc. State stays RUN. itlb_miss dominates icache_miss.
- Accepted feedback with icache_miss only: pc held, state WAIT.
- Accepted feedback with no miss: pc=fb_pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- WAIT→RUN in the first cycle icache_stalled[t]==0. The PC is unchanged, so the line is refetched.
- Events for different threads in one cycle are all applied independently.

## Timing
- pc, state and exc_* are registers. An update triggered in cycle n is visible in cycle n+1.
- thread_active is combinational from the state registers.
- exc_valid is high for exactly one cycle per accepted I-TLB miss.
- Redirect-to-fetch latency: 1 cycle. The fetch result already in flight for that thread arrives with a stale pc and is dropped by the PC compare.
- rst asserted mid-WAIT or mid-exception returns every thread to its reset state on the next edge. Any exc pulse due that cycle is suppressed.

## Structure
- Shared package `common`:
  - new typedef `thread_state_t` enum {RUN, WAIT, HALT}
  - constants BOOT_PC and EXC_VECTOR
  - existing threadid_t, vptr_t, n_threads
- One natural sub-module: `pc_slot`, holding one thread's PC register plus state FSM, instantiated N_THREADS times.
- The top level decodes events per thread and registers the exception outputs.

## Test plan
- Reset, then fb_valid thread 0 pc 0x1000 with no miss → pc[0]=0x1004 next cycle; thread_active=4'b0001.
- start thread 2 at 0x4000, then fb thread 2 pc 0x4000 with icache_miss → pc[2] held at 0x4000, thread_active[2]=0; icache_stalled[2] falls → thread_active[2]=1 next cycle.
- fb thread 1 pc 0x5000 with itlb_miss and icache_miss → pc[1]=0x2000, exc_valid=1 for one cycle, exc_thread=1, exc_epc=0x5000.
- redirect thread 0 to 0x8000 in the same cycle as fb thread 0 pc 0x1004 → pc[0]=0x8000. A following fb with pc 0x1008 is dropped.
- halt and start thread 3 in the same cycle → thread 3 stays HALT. fb with pc 0xFFFF_FFFC on a RUN thread → pc wraps to 0x0000_0000.
- rst asserted while thread 2 is in WAIT → all PCs 0x1000, thread_active=4'b0001, exc_valid=0.
